memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Shares the core's single external memory port between the instruction-fetch requester (icache fill) and the data-access requester (load/store unit). One transaction is outstanding at a time. Arbitration gives data priority by default, with an optional starvation guard that forces an instruction grant after a bounded run of data grants. The block sits between the core's fetch/memory stages and the memory bus, and owns the only sequencing of that bus.

## Interface
- `MaxDataGrants`, default 4: number of consecutive data grants, taken while an instruction request is pending, after which the instruction requester wins. Legal range 1..15. Only used when the guard is compiled in.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `instr_req_valid_i` in 1: the instruction requester has a read pending.
- `instr_req_address_i` in 32: instruction read address, word aligned.
- `instr_req_ready_o` out 1: instruction request accepted this cycle.
- `instr_rsp_valid_o` out 1: instruction read data valid; a one-cycle pulse.
- `instr_rsp_data_o` out 32: instruction read data.
- `data_req_valid_i` in 1: the data requester has a request pending.
- `data_req_address_i` in 32: data address.
- `data_req_write_i` in 1: 1 = write, 0 = read.
- `data_req_wdata_i` in 32: write data.
- `data_req_wstrb_i` in 4: byte enables.
- `data_req_ready_o` out 1: data request accepted this cycle.
- `data_rsp_valid_o` out 1: data response pulse. Asserted for writes too, as the acknowledge.
- `data_rsp_data_o` out 32: read data. Equals 0 for writes.
- `mem_req_valid_o` out 1: request presented to memory.
- `mem_req_address_o` out 32, `mem_req_write_o` out 1, `mem_req_wdata_o` out 32, `mem_req_wstrb_o` out 4: the latched request.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_rsp_valid_i` in 1: memory response valid.
- `mem_rsp_data_i` in 32: memory response data.
- `protocol_error_o` out 1: sticky flag. Set when a memory response arrives with no transaction outstanding.

## Operation
- States:
  - IDLE: accepts a request.
  - ISSUE: `mem_req_valid_o` = 1.
  - WAIT: awaiting `mem_rsp_valid_i`.
- IDLE grant, combinational:
  - If both requesters are valid: data wins, unless the guard is active with `starve_count == MaxDataGrants`, in which case instruction wins.
  - If only one is valid, it wins.
  - `*_req_ready_o` = 1 only for the winner, and only in IDLE.
- On a handshake in IDLE:
  - latch address, write, wdata and wstrb; the instruction requester forces write = 0, wstrb = 0, wdata = 0;
  - latch the owner;
  - move to ISSUE.
- ISSUE: hold the mem request stable. On `mem_req_ready_i` move to WAIT. `mem_rsp_valid_i` in the same cycle as `mem_req_ready_i` is not legal and is ignored.
- WAIT: on `mem_rsp_valid_i`:
  - register the data into the owner's `rsp_data`;
  - pulse the owner's `rsp_valid` in the next cycle;
  - move to IDLE.
- The response of the other requester is never asserted. Its `rsp_data` holds its last value.
- `mem_rsp_valid_i` in IDLE or ISSUE: ignored, and sets `protocol_error_o`. The flag clears only on reset.
- Starvation counter, 4 bits:
  - increments on each data grant while `instr_req_valid_i` = 1, saturating at `MaxDataGrants`;
  - clears on an instruction grant;
  - clears on any IDLE cycle with `instr_req_valid_i` = 0.

## Timing
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - state IDLE, counter 0, owner = instruction;
  - all outputs 0, including `protocol_error_o`, latched request fields and response data.
- Reset mid-transaction:
  - immediate return to IDLE;
  - the in-flight response is dropped; if it arrives later it sets `protocol_error_o`.
- Request handshake to `mem_req_valid_o`: 1 cycle (the ISSUE state starts in the cycle after the handshake).
- `mem_rsp_valid_i` to `*_rsp_valid_o`: 1 cycle.
- Minimum transaction with memory zero-wait: 3 cycles from the handshake to the response pulse.
- The response pulse coincides with the next IDLE cycle, so a new grant can happen in the same cycle as the response.
- Back-to-back throughput: one transaction per 3 cycles.
- Requesters must hold their request fields stable while valid is asserted and ready is low.

## Configuration
- `MEM_ARBITER_STARVATION_GUARD_EN` defined: the counter and the forced instruction grant are present.
- Undefined: strict data priority; the counter logic and `MaxDataGrants` are unused. With a continuously asserted data request, the instruction requester may starve indefinitely.

## Structure
- Package `mem_arbiter_pkg` contains:
  - `arbiter_state_e` (IDLE, ISSUE, WAIT);
  - `arbiter_owner_e` (OWNER_INSTR, OWNER_DATA);
  - `mem_request_t` struct (address, write, wdata, wstrb);
  - localparam `StarveCountWidth` = 4.
- Sub-module `starvation_counter`: the saturating counter plus the "force instruction" compare. Instantiated only under the macro.

## Test plan
- Single instruction read, address 0x100, memory returns 0xDEADBEEF with zero wait:
  - `mem_req_valid_o` rises 1 cycle after the handshake;
  - `instr_rsp_valid_o` pulses with 0xDEADBEEF 3 cycles after the handshake;
  - `data_rsp_valid_o` stays 0.
- Simultaneous instruction read 0x200 and data write 0x300 (wdata 0x12345678, wstrb 0xF):
  - data is granted first;
  - `mem_req_write_o` = 1 with those fields;
  - instruction is granted in the IDLE cycle coinciding with `data_rsp_valid_o`.
- Guard enabled, `MaxDataGrants` = 2, data valid continuously and instruction valid continuously:
  - grant order is D, D, I, D, D, I.
- Guard disabled with the same stimulus:
  - grant order is D, D, D, D…;
  - the instruction request is never ready.
- Memory stalls `mem_req_ready_i` low for 5 cycles in ISSUE:
  - the request fields are stable for all 5 cycles;
  - the move to WAIT happens on the ready cycle.
- `rst_ni` asserted during WAIT, then `mem_rsp_valid_i` pulses after release:
  - all outputs are 0 in the reset cycle;
  - no response is pulsed to either requester;
  - `protocol_error_o` = 1 and stays set.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for memory_port_arbiter and its
//            optional starvation_counter (MEM_ARBITER_STARVATION_GUARD_EN).
// Contents : arbiter_state_e, arbiter_owner_e, mem_request_t,
//            StarveCountWidth.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Width of the consecutive-data-grant counter; covers MaxDataGrants 1..15.
  localparam int StarveCountWidth = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbiter_state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arbiter_owner_e;

  typedef struct packed {
    logic [31:0] address;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_request_t;

endpackage
`default_nettype wire

// File: rtl/memory_port_arbiter_starvation_counter.sv
`default_nettype none
// ============================================================================
// Module   : starvation_counter
// Purpose  : Counts consecutive data grants taken while an instruction
//            request waits, and asks the arbiter to force an instruction
//            grant once MaxDataGrants is reached. Only instantiated when
//            MEM_ARBITER_STARVATION_GUARD_EN is defined.
// Ports    : clk_i, rst_ni        - clock, async active-low reset
//            idle_i               - arbiter is in IDLE this cycle
//            instr_req_valid_i    - instruction request pending
//            grant_instr_i        - instruction handshake this cycle
//            grant_data_i         - data handshake this cycle
//            force_instr_o        - instruction must win the next tie
// Revision : 1.0 - initial release
// ============================================================================
module starvation_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MaxDataGrants = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle_i,
  input  logic instr_req_valid_i,
  input  logic grant_instr_i,
  input  logic grant_data_i,
  output logic force_instr_o
);

  localparam logic [StarveCountWidth-1:0] MaxCount = StarveCountWidth'(MaxDataGrants);

  logic [StarveCountWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (grant_instr_i) begin
      count_d = '0;
    end else if (idle_i && !instr_req_valid_i) begin
      // Nobody is starving, so the run of data grants is broken.
      count_d = '0;
    end else if (grant_data_i && instr_req_valid_i && (count_q < MaxCount)) begin
      count_d = count_q + StarveCountWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign force_instr_o = (count_q == MaxCount);

endmodule
`default_nettype wire

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_port_arbiter
// Purpose  : Shares one external memory port between the instruction-fetch
//            and data-access requesters, one transaction outstanding at a
//            time. Data has priority; defining MEM_ARBITER_STARVATION_GUARD_EN
//            adds a guard forcing an instruction grant after MaxDataGrants
//            consecutive data grants taken while instruction was waiting.
// Ports    : clk_i, rst_ni                    - clock, async active-low reset
//            instr_req_* / instr_rsp_*        - instruction requester
//            data_req_*  / data_rsp_*         - data requester
//            mem_req_*   / mem_rsp_*          - memory bus
//            protocol_error_o                 - sticky unexpected-response flag
// Revision : 1.0 - initial release
// ============================================================================
module memory_port_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MaxDataGrants = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_valid_i,
  input  logic [31:0] instr_req_address_i,
  output logic        instr_req_ready_o,
  output logic        instr_rsp_valid_o,
  output logic [31:0] instr_rsp_data_o,

  input  logic        data_req_valid_i,
  input  logic [31:0] data_req_address_i,
  input  logic        data_req_write_i,
  input  logic [31:0] data_req_wdata_i,
  input  logic [3:0]  data_req_wstrb_i,
  output logic        data_req_ready_o,
  output logic        data_rsp_valid_o,
  output logic [31:0] data_rsp_data_o,

  output logic        mem_req_valid_o,
  output logic [31:0] mem_req_address_o,
  output logic        mem_req_write_o,
  output logic [31:0] mem_req_wdata_o,
  output logic [3:0]  mem_req_wstrb_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,

  output logic        protocol_error_o
);

  arbiter_state_e state_q, state_d;
  arbiter_owner_e owner_q, owner_d;
  mem_request_t   req_q, req_d;

  logic [31:0] instr_rsp_data_q, instr_rsp_data_d;
  logic [31:0] data_rsp_data_q, data_rsp_data_d;
  logic        instr_rsp_valid_q, instr_rsp_valid_d;
  logic        data_rsp_valid_q, data_rsp_valid_d;
  logic        protocol_error_q, protocol_error_d;

  logic grant_instr;
  logic grant_data;
  logic force_instr;
  logic rsp_accept;

  // --------------------------------------------------------------------------
  // Optional starvation guard
  // --------------------------------------------------------------------------
`ifdef MEM_ARBITER_STARVATION_GUARD_EN
  starvation_counter #(
    .MaxDataGrants(MaxDataGrants)
  ) u_starvation_counter (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .idle_i            (state_q == IDLE),
    .instr_req_valid_i (instr_req_valid_i),
    .grant_instr_i     (grant_instr),
    .grant_data_i      (grant_data),
    .force_instr_o     (force_instr)
  );
`else
  logic [StarveCountWidth-1:0] unused_max_grants;
  assign unused_max_grants = StarveCountWidth'(MaxDataGrants);
  assign force_instr       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant: a grant is also the handshake, since ready only goes to a valid
  // requester. Gated by rst_ni so every output is low while reset is held.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if ((state_q == IDLE) && rst_ni) begin
      if (data_req_valid_i && !(instr_req_valid_i && force_instr)) begin
        grant_data = 1'b1;
      end else if (instr_req_valid_i) begin
        grant_instr = 1'b1;
      end
    end
  end

  // Only a response during WAIT belongs to a transaction.
  assign rsp_accept = (state_q == WAIT) && mem_rsp_valid_i;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_instr || grant_data) state_d = ISSUE;
      // A response coinciding with mem_req_ready_i is illegal and not taken.
      ISSUE:   if (mem_req_ready_i) state_d = WAIT;
      WAIT:    if (mem_rsp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    instr_req_ready_o = grant_instr;
    data_req_ready_o  = grant_data;
    mem_req_valid_o   = (state_q == ISSUE);
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    req_d             = req_q;
    owner_d           = owner_q;
    instr_rsp_valid_d = 1'b0;
    data_rsp_valid_d  = 1'b0;
    instr_rsp_data_d  = instr_rsp_data_q;
    data_rsp_data_d   = data_rsp_data_q;

    if (grant_data) begin
      req_d.address = data_req_address_i;
      req_d.write   = data_req_write_i;
      req_d.wdata   = data_req_wdata_i;
      req_d.wstrb   = data_req_wstrb_i;
      owner_d       = OWNER_DATA;
    end else if (grant_instr) begin
      req_d.address = instr_req_address_i;
      req_d.write   = 1'b0;
      req_d.wdata   = '0;
      req_d.wstrb   = '0;
      owner_d       = OWNER_INSTR;
    end

    if (rsp_accept) begin
      if (owner_q == OWNER_DATA) begin
        data_rsp_valid_d = 1'b1;
        // Writes are acknowledged with zero data, whatever memory returns.
        data_rsp_data_d  = req_q.write ? 32'd0 : mem_rsp_data_i;
      end else begin
        instr_rsp_valid_d = 1'b1;
        instr_rsp_data_d  = mem_rsp_data_i;
      end
    end

    protocol_error_d = protocol_error_q | (mem_rsp_valid_i && (state_q != WAIT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q             <= '0;
      owner_q           <= OWNER_INSTR;
      instr_rsp_valid_q <= 1'b0;
      data_rsp_valid_q  <= 1'b0;
      instr_rsp_data_q  <= '0;
      data_rsp_data_q   <= '0;
      protocol_error_q  <= 1'b0;
    end else begin
      req_q             <= req_d;
      owner_q           <= owner_d;
      instr_rsp_valid_q <= instr_rsp_valid_d;
      data_rsp_valid_q  <= data_rsp_valid_d;
      instr_rsp_data_q  <= instr_rsp_data_d;
      data_rsp_data_q   <= data_rsp_data_d;
      protocol_error_q  <= protocol_error_d;
    end
  end

  assign mem_req_address_o = req_q.address;
  assign mem_req_write_o   = req_q.write;
  assign mem_req_wdata_o   = req_q.wdata;
  assign mem_req_wstrb_o   = req_q.wstrb;
  assign instr_rsp_valid_o = instr_rsp_valid_q;
  assign instr_rsp_data_o  = instr_rsp_data_q;
  assign data_rsp_valid_o  = data_rsp_valid_q;
  assign data_rsp_data_o   = data_rsp_data_q;
  assign protocol_error_o  = protocol_error_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_port_arbiter
// Purpose  : Directed, self-checking bench for memory_port_arbiter, with
//            MaxDataGrants = 2. Expected grant order follows
//            MEM_ARBITER_STARVATION_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  logic        instr_req_valid;
  logic [31:0] instr_req_address;
  logic        instr_req_ready;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;
  logic        data_req_valid;
  logic [31:0] data_req_address;
  logic        data_req_write;
  logic [31:0] data_req_wdata;
  logic [3:0]  data_req_wstrb;
  logic        data_req_ready;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic        mem_req_valid;
  logic [31:0] mem_req_address;
  logic        mem_req_write;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        protocol_error;

  memory_port_arbiter #(
    .MaxDataGrants(2)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .instr_req_valid_i   (instr_req_valid),
    .instr_req_address_i (instr_req_address),
    .instr_req_ready_o   (instr_req_ready),
    .instr_rsp_valid_o   (instr_rsp_valid),
    .instr_rsp_data_o    (instr_rsp_data),
    .data_req_valid_i    (data_req_valid),
    .data_req_address_i  (data_req_address),
    .data_req_write_i    (data_req_write),
    .data_req_wdata_i    (data_req_wdata),
    .data_req_wstrb_i    (data_req_wstrb),
    .data_req_ready_o    (data_req_ready),
    .data_rsp_valid_o    (data_rsp_valid),
    .data_rsp_data_o     (data_rsp_data),
    .mem_req_valid_o     (mem_req_valid),
    .mem_req_address_o   (mem_req_address),
    .mem_req_write_o     (mem_req_write),
    .mem_req_wdata_o     (mem_req_wdata),
    .mem_req_wstrb_o     (mem_req_wstrb),
    .mem_req_ready_i     (mem_req_ready),
    .mem_rsp_valid_i     (mem_rsp_valid),
    .mem_rsp_data_i      (mem_rsp_data),
    .protocol_error_o    (protocol_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic iv;
    logic dv;
    logic exp_ir;
    logic exp_dr;
  } arb_vec_t;

  typedef struct {
    logic        is_data;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mem_rdata;
    int          stall;
    logic        exp_write;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rsp;
  } txn_vec_t;

  arb_vec_t    arb_tab[4];
  txn_vec_t    txn_tab[4];
  logic        exp_order[6];
  logic [31:0] last_instr_data;
  logic [31:0] last_data_data;

  // One full transaction, starting and ending on a negedge in IDLE.
  task automatic run_txn(input int idx, input txn_vec_t v);
    string p;
    p = $sformatf("txn%0d", idx);
    if (v.is_data) begin
      data_req_valid   = 1'b1;
      data_req_address = v.addr;
      data_req_write   = v.write;
      data_req_wdata   = v.wdata;
      data_req_wstrb   = v.wstrb;
    end else begin
      instr_req_valid   = 1'b1;
      instr_req_address = v.addr;
    end
    #1;
    check({p, "_ready"}, v.is_data ? data_req_ready : instr_req_ready, 32'd1);
    @(negedge clk);
    data_req_valid  = 1'b0;
    instr_req_valid = 1'b0;
    for (int s = 0; s <= v.stall; s++) begin
      check($sformatf("%s_issue%0d_valid", p, s), mem_req_valid, 32'd1);
      check($sformatf("%s_issue%0d_addr", p, s), mem_req_address, v.addr);
      check($sformatf("%s_issue%0d_write", p, s), mem_req_write, v.exp_write);
      check($sformatf("%s_issue%0d_wdata", p, s), mem_req_wdata, v.exp_wdata);
      check($sformatf("%s_issue%0d_wstrb", p, s), mem_req_wstrb, v.exp_wstrb);
      if (s == v.stall) mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    check({p, "_wait_valid"}, mem_req_valid, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = v.mem_rdata;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    if (v.is_data) begin
      check({p, "_data_rsp_valid"}, data_rsp_valid, 32'd1);
      check({p, "_data_rsp_data"}, data_rsp_data, v.exp_rsp);
      check({p, "_instr_rsp_valid"}, instr_rsp_valid, 32'd0);
      check({p, "_instr_rsp_hold"}, instr_rsp_data, last_instr_data);
      last_data_data = v.exp_rsp;
    end else begin
      check({p, "_instr_rsp_valid"}, instr_rsp_valid, 32'd1);
      check({p, "_instr_rsp_data"}, instr_rsp_data, v.exp_rsp);
      check({p, "_data_rsp_valid"}, data_rsp_valid, 32'd0);
      check({p, "_data_rsp_hold"}, data_rsp_data, last_data_data);
      last_instr_data = v.exp_rsp;
    end
    @(negedge clk);
    check({p, "_pulse_end"}, {30'd0, instr_rsp_valid, data_rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arb_tab[0] = '{iv: 1'b0, dv: 1'b0, exp_ir: 1'b0, exp_dr: 1'b0};
    arb_tab[1] = '{iv: 1'b1, dv: 1'b0, exp_ir: 1'b1, exp_dr: 1'b0};
    arb_tab[2] = '{iv: 1'b0, dv: 1'b1, exp_ir: 1'b0, exp_dr: 1'b1};
    arb_tab[3] = '{iv: 1'b1, dv: 1'b1, exp_ir: 1'b0, exp_dr: 1'b1};

    txn_tab[0] = '{is_data: 1'b0, write: 1'b0, addr: 32'h0000_0100, wdata: 32'h0,
                   wstrb: 4'h0, mem_rdata: 32'hDEAD_BEEF, stall: 0,
                   exp_write: 1'b0, exp_wdata: 32'h0, exp_wstrb: 4'h0, exp_rsp: 32'hDEAD_BEEF};
    txn_tab[1] = '{is_data: 1'b1, write: 1'b0, addr: 32'h0000_0300, wdata: 32'h1111_1111,
                   wstrb: 4'h0, mem_rdata: 32'hCAFE_F00D, stall: 0,
                   exp_write: 1'b0, exp_wdata: 32'h1111_1111, exp_wstrb: 4'h0, exp_rsp: 32'hCAFE_F00D};
    txn_tab[2] = '{is_data: 1'b1, write: 1'b1, addr: 32'h0000_0304, wdata: 32'hA5A5_A5A5,
                   wstrb: 4'h3, mem_rdata: 32'h7777_7777, stall: 5,
                   exp_write: 1'b1, exp_wdata: 32'hA5A5_A5A5, exp_wstrb: 4'h3, exp_rsp: 32'h0};
    txn_tab[3] = '{is_data: 1'b0, write: 1'b0, addr: 32'h0000_0104, wdata: 32'h0,
                   wstrb: 4'h0, mem_rdata: 32'h0BAD_F00D, stall: 2,
                   exp_write: 1'b0, exp_wdata: 32'h0, exp_wstrb: 4'h0, exp_rsp: 32'h0BAD_F00D};

`ifdef MEM_ARBITER_STARVATION_GUARD_EN
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    last_instr_data   = 32'h0;
    last_data_data    = 32'h0;
    rst_ni            = 1'b0;
    instr_req_valid   = 1'b1;
    instr_req_address = 32'h0;
    data_req_valid    = 1'b1;
    data_req_address  = 32'h0;
    data_req_write    = 1'b0;
    data_req_wdata    = 32'h0;
    data_req_wstrb    = 4'h0;
    mem_req_ready     = 1'b0;
    mem_rsp_valid     = 1'b0;
    mem_rsp_data      = 32'h0;

    // Reset state, with both requesters valid: nothing may be granted.
    @(negedge clk);
    @(negedge clk);
    check("rst_instr_ready", instr_req_ready, 32'd0);
    check("rst_data_ready", data_req_ready, 32'd0);
    check("rst_mem_valid", mem_req_valid, 32'd0);
    check("rst_mem_fields", {mem_req_address ^ mem_req_wdata, 23'd0, mem_req_write, mem_req_wstrb} == 60'd0, 32'd1);
    check("rst_rsp", {29'd0, instr_rsp_valid, data_rsp_valid, protocol_error}, 32'd0);
    check("rst_rsp_data", instr_rsp_data | data_rsp_data, 32'd0);
    instr_req_valid = 1'b0;
    data_req_valid  = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Combinational arbitration in IDLE; requests withdrawn before the edge.
    for (int i = 0; i < 4; i++) begin
      instr_req_valid = arb_tab[i].iv;
      data_req_valid  = arb_tab[i].dv;
      #1;
      check($sformatf("arb%0d_instr_ready", i), instr_req_ready, arb_tab[i].exp_ir);
      check($sformatf("arb%0d_data_ready", i), data_req_ready, arb_tab[i].exp_dr);
      instr_req_valid = 1'b0;
      data_req_valid  = 1'b0;
      @(negedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      run_txn(i, txn_tab[i]);
    end
    check("no_proto_err", protocol_error, 32'd0);

    // Simultaneous instruction read and data write: data first, then
    // instruction granted in the IDLE cycle carrying the data response.
    instr_req_valid   = 1'b1;
    instr_req_address = 32'h0000_0200;
    data_req_valid    = 1'b1;
    data_req_address  = 32'h0000_0300;
    data_req_write    = 1'b1;
    data_req_wdata    = 32'h1234_5678;
    data_req_wstrb    = 4'hF;
    #1;
    check("sim_data_ready", data_req_ready, 32'd1);
    check("sim_instr_ready", instr_req_ready, 32'd0);
    @(negedge clk);
    data_req_valid = 1'b0;
    check("sim_d_addr", mem_req_address, 32'h0000_0300);
    check("sim_d_write", mem_req_write, 32'd1);
    check("sim_d_wdata", mem_req_wdata, 32'h1234_5678);
    check("sim_d_wstrb", mem_req_wstrb, 32'hF);
    check("sim_instr_busy", instr_req_ready, 32'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("sim_d_rsp_valid", data_rsp_valid, 32'd1);
    check("sim_d_rsp_data", data_rsp_data, 32'h0);
    check("sim_i_ready_at_rsp", instr_req_ready, 32'd1);
    @(negedge clk);
    instr_req_valid = 1'b0;
    check("sim_i_addr", mem_req_address, 32'h0000_0200);
    check("sim_i_write", mem_req_write, 32'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h2222_2222;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("sim_i_rsp_valid", instr_rsp_valid, 32'd1);
    check("sim_i_rsp_data", instr_rsp_data, 32'h2222_2222);
    @(negedge clk);

    // Both requesters held valid, zero-wait memory: grant order.
    instr_req_valid   = 1'b1;
    instr_req_address = 32'h0000_0400;
    data_req_valid    = 1'b1;
    data_req_address  = 32'h0000_0500;
    data_req_write    = 1'b0;
    for (int g = 0; g < 6; g++) begin
      #1;
      check($sformatf("order%0d_data", g), data_req_ready, exp_order[g]);
      check($sformatf("order%0d_instr", g), instr_req_ready, !exp_order[g]);
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h100 + g;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    instr_req_valid = 1'b0;
    data_req_valid  = 1'b0;
    @(negedge clk);

    // Reset during WAIT; late response must only raise the error flag.
    data_req_valid   = 1'b1;
    data_req_address = 32'h0000_0600;
    @(negedge clk);
    data_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_mem_addr", mem_req_address, 32'h0);
    check("mid_rst_mem_valid", mem_req_valid, 32'd0);
    check("mid_rst_rsp_data", instr_rsp_data | data_rsp_data, 32'h0);
    check("mid_rst_flags", {29'd0, instr_rsp_valid, data_rsp_valid, protocol_error}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h9999_9999;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("late_rsp_no_pulse", {30'd0, instr_rsp_valid, data_rsp_valid}, 32'd0);
    check("late_rsp_proto_err", protocol_error, 32'd1);
    repeat (3) @(negedge clk);
    check("proto_err_sticky", protocol_error, 32'd1);
    check("late_rsp_data", instr_rsp_data | data_rsp_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
